// File: rtl/ss_pixel_locator.sv
// Spaceship pixel locator: frame-synchronous commit of sprite position/angle plus per-pixel window test.
// Optional macro SS_BLINK_EN gates sprite visibility with the blink input.
module ss_pixel_locator #(
  parameter int SS_SIZE      = 36,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int ANGLE_AMOUNT = 16,
  parameter int ROT_FRAMES   = 8,
  parameter int X_INIT       = 302,
  parameter int Y_INIT       = 222
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       frame_start,
  input  logic       rot_left,
  input  logic       rot_right,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       pos_valid,
  input  logic       blink,
  output logic       pos_pending,
  output logic       is_SS_in_pixel,
  output logic [9:0] SS_hc,
  output logic [9:0] SS_vc,
  output logic [3:0] SS_angle
);

  localparam int         HOLD_W    = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ROT_FRAMES - 1);
  localparam logic [9:0] X_MAX     = 10'(H_ACTIVE - SS_SIZE);
  localparam logic [9:0] Y_MAX     = 10'(V_ACTIVE - SS_SIZE);
  localparam logic [3:0] ANGLE_MSK = 4'(ANGLE_AMOUNT - 1);

  logic [9:0]        r_x, r_y, r_sx, r_sy;
  logic              r_pend;
  logic [HOLD_W-1:0] r_hold;
  logic [3:0]        r_angle;
  logic [3:0]        r_frame_cnt;
  logic              r_in;
  logic [9:0]        r_ss_hc, r_ss_vc;

  logic [9:0]  w_clamp_x, w_clamp_y;
  logic [10:0] w_x_end, w_y_end;
  logic        w_in, w_show, w_one_btn;

  assign w_clamp_x = (pos_x > X_MAX) ? X_MAX : pos_x;
  assign w_clamp_y = (pos_y > Y_MAX) ? Y_MAX : pos_y;
  assign w_one_btn = rot_left ^ rot_right;

  // Window bounds are 11 bits so X+SS_SIZE cannot wrap.
  assign w_x_end = {1'b0, r_x} + 11'(SS_SIZE);
  assign w_y_end = {1'b0, r_y} + 11'(SS_SIZE);
  assign w_in    = ({1'b0, hc} >= {1'b0, r_x}) && ({1'b0, hc} < w_x_end) &&
                   ({1'b0, vc} >= {1'b0, r_y}) && ({1'b0, vc} < w_y_end);

`ifdef SS_BLINK_EN
  assign w_show = w_in && !(blink && r_frame_cnt[3]);
`else
  logic w_unused;
  assign w_unused = ^{blink, r_frame_cnt};
  assign w_show   = w_in;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_x         <= 10'(X_INIT);
      r_y         <= 10'(Y_INIT);
      r_sx        <= 10'(X_INIT);
      r_sy        <= 10'(Y_INIT);
      r_pend      <= 1'b0;
      r_hold      <= '0;
      r_angle     <= 4'd0;
      r_frame_cnt <= 4'd0;
      r_in        <= 1'b0;
      r_ss_hc     <= 10'd0;
      r_ss_vc     <= 10'd0;
    end else begin
      if (frame_start) begin
        r_frame_cnt <= r_frame_cnt + 4'd1;
        // A strobe on the commit cycle bypasses the shadow entirely.
        if (pos_valid) begin
          r_x    <= w_clamp_x;
          r_y    <= w_clamp_y;
          r_sx   <= w_clamp_x;
          r_sy   <= w_clamp_y;
          r_pend <= 1'b0;
        end else if (r_pend) begin
          r_x    <= r_sx;
          r_y    <= r_sy;
          r_pend <= 1'b0;
        end
        if (w_one_btn) begin
          if (r_hold == HOLD_LAST) begin
            r_hold  <= '0;
            r_angle <= (rot_right ? r_angle + 4'd1 : r_angle - 4'd1) & ANGLE_MSK;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end else begin
          r_hold <= '0;
        end
      end else if (pos_valid) begin
        r_sx   <= w_clamp_x;
        r_sy   <= w_clamp_y;
        r_pend <= 1'b1;
      end
      r_in    <= w_show;
      r_ss_hc <= w_show ? (hc - r_x) : 10'd0;
      r_ss_vc <= w_show ? (vc - r_y) : 10'd0;
    end
  end

  assign pos_pending    = r_pend;
  assign is_SS_in_pixel = r_in;
  assign SS_hc          = r_ss_hc;
  assign SS_vc          = r_ss_vc;
  assign SS_angle       = r_angle;

endmodule

// File: tb/tb_ss_pixel_locator.sv
// Self-checking bench for ss_pixel_locator: directed scenarios plus randomized traffic against a frame-level model.
module tb_ss_pixel_locator;

  localparam int SS = 36;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] hc = '0, vc = '0, pos_x = '0, pos_y = '0;
  logic       frame_start = 1'b0, rot_left = 1'b0, rot_right = 1'b0;
  logic       pos_valid = 1'b0, blink = 1'b0;
  logic       pos_pending, is_SS_in_pixel;
  logic [9:0] SS_hc, SS_vc;
  logic [3:0] SS_angle;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: committed/requested position, consecutive-frame hold count, angle, frame count.
  int m_x, m_y, m_sx, m_sy, m_pend, m_ang, m_hold, m_fc;
  int e_in, e_hc, e_vc;

  ss_pixel_locator dut (
    .CLK(CLK), .RST(RST), .hc(hc), .vc(vc), .frame_start(frame_start),
    .rot_left(rot_left), .rot_right(rot_right), .pos_x(pos_x), .pos_y(pos_y),
    .pos_valid(pos_valid), .blink(blink), .pos_pending(pos_pending),
    .is_SS_in_pixel(is_SS_in_pixel), .SS_hc(SS_hc), .SS_vc(SS_vc), .SS_angle(SS_angle)
  );

  initial forever #5 CLK = ~CLK;

  // Advance one clock, then predict what the DUT must show from the inputs it just sampled.
  task automatic tick();
    int  h, v, cx, cy;
    bit  hide;
    h = int'(hc);
    v = int'(vc);
    @(posedge CLK);
    #1;
    if (RST) begin
      m_x = 302; m_y = 222; m_sx = 302; m_sy = 222;
      m_pend = 0; m_ang = 0; m_hold = 0; m_fc = 0;
      e_in = 0; e_hc = 0; e_vc = 0;
    end else begin
      hide = 1'b0;
`ifdef SS_BLINK_EN
      hide = blink && (m_fc >= 8);
`endif
      if (!hide && h >= m_x && h < m_x + SS && v >= m_y && v < m_y + SS) begin
        e_in = 1; e_hc = h - m_x; e_vc = v - m_y;
      end else begin
        e_in = 0; e_hc = 0; e_vc = 0;
      end
      cx = (int'(pos_x) > 640 - SS) ? 640 - SS : int'(pos_x);
      cy = (int'(pos_y) > 480 - SS) ? 480 - SS : int'(pos_y);
      if (frame_start) begin
        if (pos_valid) begin
          m_x = cx; m_y = cy; m_sx = cx; m_sy = cy; m_pend = 0;
        end else if (m_pend == 1) begin
          m_x = m_sx; m_y = m_sy; m_pend = 0;
        end
        if (rot_left != rot_right) begin
          m_hold = m_hold + 1;
          if (m_hold == 8) begin
            m_hold = 0;
            m_ang  = (m_ang + (rot_right ? 1 : 15)) % 16;
          end
        end else begin
          m_hold = 0;
        end
        m_fc = (m_fc + 1) % 16;
      end else if (pos_valid) begin
        m_sx = cx; m_sy = cy; m_pend = 1;
      end
    end
    frame_start = 1'b0;
    pos_valid   = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      tick();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; pos_valid = 1'b1; pos_x = 10'd5; pos_y = 10'd5;
    frame_start = 1'b1; rot_right = 1'b1; hc = 10'd302; vc = 10'd222;
    tick();
    rot_right = 1'b0;
    tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b0 || SS_hc !== 10'd0 || SS_vc !== 10'd0 ||
        SS_angle !== 4'd0 || pos_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got in=%0b hc=%0d vc=%0d ang=%0d pend=%0b required all zero",
               is_SS_in_pixel, SS_hc, SS_vc, SS_angle, pos_pending);
    end
    RST = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_window();
    hc = 10'd302; vc = 10'd222; tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b1 || SS_hc !== 10'd0 || SS_vc !== 10'd0) begin
      n_fail++;
      $display("FAIL window_origin: got in=%0b hc=%0d vc=%0d required 1 0 0", is_SS_in_pixel, SS_hc, SS_vc);
    end
    hc = 10'd338; tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b0 || SS_hc !== 10'd0) begin
      n_fail++;
      $display("FAIL window_right_edge: got in=%0b hc=%0d required 0 0", is_SS_in_pixel, SS_hc);
    end
    hc = 10'd337; vc = 10'd257; tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b1 || SS_hc !== 10'd35 || SS_vc !== 10'd35) begin
      n_fail++;
      $display("FAIL window_corner: got in=%0b hc=%0d vc=%0d required 1 35 35", is_SS_in_pixel, SS_hc, SS_vc);
    end
    hc = 10'd310; vc = 10'd258; tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b0 || SS_vc !== 10'd0) begin
      n_fail++;
      $display("FAIL window_bottom_edge: got in=%0b vc=%0d required 0 0", is_SS_in_pixel, SS_vc);
    end
    $display("test_window done");
  endtask

  task automatic test_pos_capture();
    pos_x = 10'd700; pos_y = 10'd10; pos_valid = 1'b1; hc = 10'd302; vc = 10'd222;
    tick();
    tick();
    n_checks++;
    if (pos_pending !== 1'b1 || is_SS_in_pixel !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_pending: got pend=%0b in=%0b required 1 1", pos_pending, is_SS_in_pixel);
    end
    frame_start = 1'b1; tick();
    n_checks++;
    if (pos_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_clears_pending: got %0b required 0", pos_pending);
    end
    hc = 10'd604; vc = 10'd10; tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b1 || SS_hc !== 10'd0 || SS_vc !== 10'd0) begin
      n_fail++;
      $display("FAIL clamped_origin: got in=%0b hc=%0d vc=%0d required 1 0 0", is_SS_in_pixel, SS_hc, SS_vc);
    end
    hc = 10'd639; vc = 10'd45; tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b1 || SS_hc !== 10'd35 || SS_vc !== 10'd35) begin
      n_fail++;
      $display("FAIL clamped_corner: got in=%0b hc=%0d vc=%0d required 1 35 35", is_SS_in_pixel, SS_hc, SS_vc);
    end
    $display("test_pos_capture done");
  endtask

  task automatic test_last_write_and_bypass();
    pos_x = 10'd100; pos_y = 10'd100; pos_valid = 1'b1; tick();
    pos_x = 10'd200; pos_y = 10'd200; pos_valid = 1'b1; tick();
    frame_start = 1'b1; tick();
    hc = 10'd200; vc = 10'd200; tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b1 || SS_hc !== 10'd0 || SS_vc !== 10'd0) begin
      n_fail++;
      $display("FAIL last_write_wins: got in=%0b hc=%0d vc=%0d required 1 0 0", is_SS_in_pixel, SS_hc, SS_vc);
    end
    hc = 10'd100; vc = 10'd100; tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_write_visible: got in=%0b required 0", is_SS_in_pixel);
    end
    pos_x = 10'd50; pos_y = 10'd50; pos_valid = 1'b1; frame_start = 1'b1; tick();
    n_checks++;
    if (pos_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_pending: got %0b required 0", pos_pending);
    end
    hc = 10'd85; vc = 10'd85; tick();
    n_checks++;
    if (is_SS_in_pixel !== 1'b1 || SS_hc !== 10'd35 || SS_vc !== 10'd35) begin
      n_fail++;
      $display("FAIL bypass_commit: got in=%0b hc=%0d vc=%0d required 1 35 35", is_SS_in_pixel, SS_hc, SS_vc);
    end
    $display("test_last_write_and_bypass done");
  endtask

  task automatic test_rotation();
    rot_right = 1'b1;
    frames(7);
    n_checks++;
    if (SS_angle !== 4'd0) begin
      n_fail++;
      $display("FAIL rot_7_frames: got %0d required 0", SS_angle);
    end
    frame_start = 1'b1; tick();
    n_checks++;
    if (SS_angle !== 4'd1) begin
      n_fail++;
      $display("FAIL rot_right_step: got %0d required 1", SS_angle);
    end
    frames(120);
    n_checks++;
    if (SS_angle !== 4'd0) begin
      n_fail++;
      $display("FAIL rot_right_wrap: got %0d required 0", SS_angle);
    end
    rot_right = 1'b0; rot_left = 1'b1;
    frames(8);
    n_checks++;
    if (SS_angle !== 4'd15) begin
      n_fail++;
      $display("FAIL rot_left_wrap: got %0d required 15", SS_angle);
    end
    rot_right = 1'b1;
    frames(20);
    n_checks++;
    if (SS_angle !== 4'd15) begin
      n_fail++;
      $display("FAIL both_buttons: got %0d required 15", SS_angle);
    end
    rot_left = 1'b0;
    frames(5);
    rot_right = 1'b0;
    frames(1);
    rot_right = 1'b1;
    frames(7);
    n_checks++;
    if (SS_angle !== 4'd15) begin
      n_fail++;
      $display("FAIL release_restart: got %0d required 15", SS_angle);
    end
    frames(1);
    n_checks++;
    if (SS_angle !== 4'd0 || SS_angle !== 4'(m_ang)) begin
      n_fail++;
      $display("FAIL release_full_hold: got %0d required 0 (model %0d)", SS_angle, m_ang);
    end
    rot_right = 1'b0;
    $display("test_rotation done");
  endtask

  task automatic test_blink();
    blink = 1'b1;
    for (int f = 0; f < 16; f++) begin
      hc = 10'(m_x + 3); vc = 10'(m_y + 4);
      tick();
      n_checks++;
`ifdef SS_BLINK_EN
      if (is_SS_in_pixel !== 1'(e_in) || e_in != ((m_fc < 8) ? 1 : 0)) begin
`else
      if (is_SS_in_pixel !== 1'b1 || e_in != 1) begin
`endif
        n_fail++;
        $display("FAIL blink_frame_%0d: got in=%0b required %0d", m_fc, is_SS_in_pixel, e_in);
      end
      frame_start = 1'b1; tick();
    end
    blink = 1'b0;
    $display("test_blink done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      RST         = ($urandom_range(0, 499) == 0);
      frame_start = ($urandom_range(0, 7) == 0);
      pos_valid   = ($urandom_range(0, 11) == 0);
      pos_x       = 10'($urandom_range(0, 1023));
      pos_y       = 10'($urandom_range(0, 1023));
      blink       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        rot_left  = 1'($urandom_range(0, 1));
        rot_right = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        hc = 10'($urandom_range(0, 1023));
        vc = 10'($urandom_range(0, 1023));
      end else begin
        hc = 10'(m_x + $urandom_range(0, SS + 3) - 2);
        vc = 10'(m_y + $urandom_range(0, SS + 3) - 2);
      end
      tick();
      n_checks++;
      if (is_SS_in_pixel !== 1'(e_in) || SS_hc !== 10'(e_hc) || SS_vc !== 10'(e_vc) ||
          SS_angle !== 4'(m_ang) || pos_pending !== 1'(m_pend)) begin
        n_fail++;
        $display("FAIL random_%0d: got in=%0b hc=%0d vc=%0d ang=%0d pend=%0b required %0d %0d %0d %0d %0d",
                 i, is_SS_in_pixel, SS_hc, SS_vc, SS_angle, pos_pending, e_in, e_hc, e_vc, m_ang, m_pend);
      end
    end
    RST = 1'b0; rot_left = 1'b0; rot_right = 1'b0; blink = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_window();
    test_pos_capture();
    test_last_write_and_bypass();
    test_rotation();
    test_blink();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ss_pixel_locator.md
Name: ss_pixel_locator

Overview:
- Sits directly upstream of the spaceship sprite ROM stage.
- Takes the VGA pixel counters, a requested ship position, and the rotate buttons.
- Produces the ROM addressing inputs: in-sprite flag, sprite-local column/row, angle index.
- Position and angle are committed only at frame boundaries, so the sprite never tears mid-frame.

Parameters:
- SS_SIZE, 36, sprite edge length in pixels.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- ANGLE_AMOUNT, 16, number of rotation steps; power of two, matches the 4-bit angle.
- ROT_FRAMES, 8, frames a rotate button must be held per angle step.
- X_INIT, 302, reset x of the sprite top-left corner.
- Y_INIT, 222, reset y of the sprite top-left corner.

Ports:
- CLK  in  1  pixel clock.
- RST  in  1  reset; synchronous, active-high.
- hc  in  10  current horizontal pixel counter.
- vc  in  10  current vertical line counter.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- rot_left  in  1  debounced level: rotate counter-clockwise.
- rot_right  in  1  debounced level: rotate clockwise.
- pos_x  in  10  requested top-left x.
- pos_y  in  10  requested top-left y.
- pos_valid  in  1  one-cycle strobe: capture pos_x/pos_y.
- blink  in  1  invincibility blink request; only used with SS_BLINK_EN.
- pos_pending  out  1  a captured position awaits commit.
- is_SS_in_pixel  out  1  current pixel lies inside the sprite window.
- SS_hc  out  10  sprite-local column, 0..SS_SIZE-1.
- SS_vc  out  10  sprite-local row, 0..SS_SIZE-1.
- SS_angle  out  4  committed angle index.

Behaviour:
- Reset values:
  - is_SS_in_pixel=0, SS_hc=0, SS_vc=0, SS_angle=0, pos_pending=0.
  - Committed and shadow position = X_INIT/Y_INIT.
  - Rotation hold counter = 0; frame counter = 0.
- RST has priority over every other input in the same cycle.
- Position capture:
  - On pos_valid, clamp x to min(pos_x, H_ACTIVE-SS_SIZE) and y to min(pos_y, V_ACTIVE-SS_SIZE).
  - Store the clamped values in the shadow register and set pos_pending=1.
  - A later pos_valid before commit overwrites the shadow (last write wins).
- Position commit:
  - On frame_start with pos_pending=1: shadow moves to committed; pos_pending clears the next cycle.
  - pos_valid coincident with frame_start: the new clamped value bypasses straight to committed; pos_pending stays 0.
- Rotation, evaluated only on frame_start:
  - Exactly one button high: hold counter increments.
  - When the counter equals ROT_FRAMES-1, step the angle and clear the counter:
    - rot_right gives +1 mod 16 (15 wraps to 0).
    - rot_left gives -1 mod 16 (0 wraps to 15).
  - Neither or both buttons high: counter clears; angle held.
  - SS_angle changes only in the cycle after frame_start.
- Window test:
  - Inside = (hc ≥ X) && (hc < X+SS_SIZE) && (vc ≥ Y) && (vc < Y+SS_SIZE), where X/Y are the committed position.
  - Sums are computed 11 bits wide so there is no overflow.
- Outputs:
  - Registered; latency 1 cycle from hc/vc.
  - Inside: SS_hc=hc-X, SS_vc=vc-Y, is_SS_in_pixel=1.
  - Outside: is_SS_in_pixel=0, SS_hc=0, SS_vc=0 (downstream ROM then reads address 0).
- Frame counter: 4-bit, increments on every frame_start, wraps freely.

Optional Feature:
- Macro: SS_BLINK_EN.
- Defined:
  - While blink=1, force is_SS_in_pixel=0 whenever frame counter bit 3 is 1, i.e. 8 frames hidden, 8 shown.
  - SS_hc/SS_vc behave as if the pixel is outside.
- Undefined: blink is ignored; no gating logic is synthesised.

Test Plan:
- Reset, then X=302,Y=222; drive hc=302,vc=222 → next cycle is_SS_in_pixel=1, SS_hc=0, SS_vc=0. Drive hc=338 → is_SS_in_pixel=0, SS_hc=0.
- pos_valid with pos_x=700,pos_y=10 mid-frame → pos_pending=1, window unchanged. After frame_start, hc=604,vc=10 → inside, SS_hc=0. hc=639,vc=45 → SS_hc=35, SS_vc=35.
- Two pos_valid (100,100) then (200,200) before frame_start → committed (200,200). pos_valid (50,50) on the frame_start cycle → committed (50,50), pos_pending=0.
- rot_right held for 8 frame_start pulses → SS_angle 0→1. Held 120 more → wraps to 0. From 0, rot_left for 8 frames → 15.
- Both buttons held for 20 frames → angle unchanged. Release after 5 frames of rot_right, then press again → needs a full 8 frames to step.
- With SS_BLINK_EN and blink=1, pixel inside window → is_SS_in_pixel=0 for frame counter 8..15 and 1 for 0..7. Without the macro → always 1.
